// File: rtl/dac_mode_sequencer.sv
// DAC reconfiguration sequencer: debounces the MCU sample-rate config, then mutes,
// resets and re-clocks the DAC/PLL in order before unmuting.
module dac_mode_sequencer #(
    parameter int MUTE_CYCLES   = 2400,
    parameter int RESET_CYCLES  = 240,
    parameter int SETTLE_CYCLES = 24000,
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_mcu,
    input  logic       mcu_44_48,
    input  logic       mcu_dsd_on,
    input  logic [1:0] mcu_f,
    input  logic       mcu_mute,
    input  logic       mcu_dac_reset,
    output logic       dac_44_48,
    output logic       dac_dsd,
    output logic [1:0] dac_f,
    output logic       dac_mute,
    output logic       dac_reset,
    output logic [1:0] pll_s_o,
    output logic       pll_s1_oe,
    output logic       busy
);
    localparam int MAX_MR = (MUTE_CYCLES > RESET_CYCLES) ? MUTE_CYCLES : RESET_CYCLES;
    localparam int MAX_CY = (MAX_MR > SETTLE_CYCLES) ? MAX_MR : SETTLE_CYCLES;
    localparam int CW     = $clog2(MAX_CY + 1);
    localparam int SW     = $clog2(STABLE_CYCLES + 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_MUTE   = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [5:0]    sync1, sync2;
    logic [3:0]    sync_cfg, cfg, prev_cfg;
    logic          sync_mute, sync_rstn;
    logic [1:0]    state, state_nx;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stab_cnt;
    logic          pending, first, load;

    always_ff @(posedge clk or negedge reset_mcu) begin
        if (!reset_mcu) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {mcu_44_48, mcu_f, mcu_dsd_on, mcu_mute, mcu_dac_reset};
            sync2 <= sync1;
        end
    end

    assign sync_cfg  = sync2[5:2];
    assign sync_mute = sync2[1];
    assign sync_rstn = sync2[0];

    // Count consecutive cycles of one unchanged, differing config; any new value restarts at 1.
    assign pending = (stab_cnt >= SW'(STABLE_CYCLES));

    always_ff @(posedge clk or negedge reset_mcu) begin
        if (!reset_mcu) begin
            prev_cfg <= '0;
            stab_cnt <= '0;
        end else begin
            prev_cfg <= sync_cfg;
            if (load || sync_cfg == cfg)
                stab_cnt <= '0;
            else if (sync_cfg != prev_cfg)
                stab_cnt <= SW'(1);
            else if (!pending)
                stab_cnt <= stab_cnt + SW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:    if (pending) state_nx = S_MUTE;
            S_MUTE:   if (cnt == CW'(MUTE_CYCLES - 1)) state_nx = S_HOLD;
            S_HOLD:   if (cnt == CW'(RESET_CYCLES - 1)) state_nx = S_SETTLE;
            default: begin
                if (pending) state_nx = S_HOLD;
                else if (cnt == CW'(SETTLE_CYCLES - 1)) state_nx = S_RUN;
            end
        endcase
    end

    // The first clock after reset release counts as a RESET_HOLD entry.
    assign load = first || (state != S_HOLD && state_nx == S_HOLD);

    always_ff @(posedge clk or negedge reset_mcu) begin
        if (!reset_mcu) begin
            state <= S_HOLD;
            cnt   <= '0;
            first <= 1'b1;
        end else begin
            state <= state_nx;
            first <= 1'b0;
            if (state_nx != state || state == S_RUN)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_mcu) begin
        if (!reset_mcu) begin
            cfg       <= '0;
            pll_s_o   <= 2'b00;
            pll_s1_oe <= 1'b1;
        end else if (load) begin
            cfg <= sync_cfg;
            // x3 needs S1 floating; S0 low.
            case (sync_cfg[2:1])
                2'b00:   begin pll_s_o <= 2'b00; pll_s1_oe <= 1'b1; end
                2'b01:   begin pll_s_o <= 2'b10; pll_s1_oe <= 1'b1; end
                2'b10:   begin pll_s_o <= 2'b01; pll_s1_oe <= 1'b1; end
                default: begin pll_s_o <= 2'b00; pll_s1_oe <= 1'b0; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_mcu) begin
        if (!reset_mcu) begin
            dac_mute  <= 1'b1;
            dac_reset <= 1'b0;
        end else begin
            dac_mute  <= sync_mute || (state != S_RUN);
            dac_reset <= sync_rstn && (state != S_HOLD);
        end
    end

    assign dac_44_48 = cfg[3];
    assign dac_f     = cfg[2:1];
    assign dac_dsd   = cfg[0];
    assign busy      = (state != S_RUN);
endmodule

// File: doc/dac_mode_sequencer.md
DAC_MODE_SEQUENCER -- requirements
Module: dac_mode_sequencer

Interface
REQ-001 SHALL have parameter MUTE_CYCLES, default 2400: cycles DAC is muted before reconfiguration (100 us at 24 MHz).
REQ-002 SHALL have parameter RESET_CYCLES, default 240: cycles dac_reset is held asserted.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 24000: PLL/DAC settle cycles before unmute.
REQ-004 SHALL have parameter STABLE_CYCLES, default 16: cycles a changed MCU config must hold before it is accepted.
REQ-005 SHALL have clk  in  1  24 MHz logic clock; all flops on rising edge.
REQ-006 SHALL have reset_mcu  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have mcu_44_48, mcu_dsd_on  in  1 each  MCU config (0=44/1=48; 0=DSD/1=PCM), asynchronous to clk.
REQ-008 SHALL have mcu_f  in  2  MCU sample-rate multiple, asynchronous.
REQ-009 SHALL have mcu_mute  in  1  MCU mute request, active-high, asynchronous.
REQ-010 SHALL have mcu_dac_reset  in  1  MCU DAC reset request, active-low, asynchronous.
REQ-011 SHALL have dac_44_48, dac_dsd  out  1 each; dac_f  out  2: applied DAC config.
REQ-012 SHALL have dac_mute  out  1  active-high; dac_reset  out  1  active-low.
REQ-013 SHALL have pll_s_o  out  2  NB3N502 S[1:0] drive value; pll_s1_oe  out  1  0 tri-states S1.
REQ-014 SHALL have busy  out  1  high whenever the FSM is not in RUN.

Function
REQ-015 All MCU inputs SHALL pass a 2-flop synchronizer before any use.
REQ-016 Config word cfg = {44_48, f, dsd_on} (4 bits); applied copy SHALL be held in registers driving dac_* outputs.
REQ-017 A change SHALL be pending when synced cfg differs from applied cfg for STABLE_CYCLES consecutive cycles; any reversion or further change restarts the stability count.
REQ-018 FSM states: RUN, MUTE_WAIT, RESET_HOLD, SETTLE; one shared down/up counter, wide enough for max parameter.
REQ-019 RUN: on pending change -> MUTE_WAIT, counter cleared.
REQ-020 MUTE_WAIT: after MUTE_CYCLES cycles -> RESET_HOLD.
REQ-021 RESET_HOLD entry cycle: applied cfg SHALL load the synced cfg and pll_s SHALL update per REQ-025; after RESET_CYCLES cycles -> SETTLE.
REQ-022 SETTLE: after SETTLE_CYCLES cycles -> RUN; a pending change in SETTLE SHALL return to RESET_HOLD (no extra MUTE_WAIT, mute stays asserted).
REQ-023 Pending changes during MUTE_WAIT or RESET_HOLD SHALL be ignored until the next RESET_HOLD entry or RUN.
REQ-024 dac_mute = synced mcu_mute OR (state != RUN); dac_reset = synced mcu_dac_reset AND (state != RESET_HOLD); both registered (1-cycle latency).
REQ-025 PLL map from applied f: 00 -> S=00, oe=1 (x2); 01 -> S=10, oe=1 (x4); 10 -> S=01, oe=1 (x5); 11 -> S0=0, oe=0 (x3).
REQ-026 pll_s_o/pll_s1_oe SHALL only change on RESET_HOLD entry.
REQ-027 Synced mcu_mute and mcu_dac_reset SHALL act directly in RUN without starting a sequence.

Reset
REQ-028 While reset_mcu=0: state RESET_HOLD, counter 0, applied cfg 0, dac_mute=1, dac_reset=0, pll_s_o=00, pll_s1_oe=1, busy=1, sync flops 0.
REQ-029 First clock after release SHALL be treated as RESET_HOLD entry (cfg load per REQ-021), then normal sequence to RUN.
REQ-030 Reset assertion mid-sequence SHALL abort immediately to REQ-028 values.

Verification
REQ-031 Reset release with mcu cfg {1,01,1} -> dac_reset low RESET_CYCLES, pll_s_o=10, busy low and dac_mute low after ~RESET_CYCLES+SETTLE_CYCLES+sync cycles.
REQ-032 In RUN, change mcu_f 01->10 held -> after STABLE_CYCLES+2 dac_mute=1; MUTE_CYCLES later dac_f=10, pll_s_o=01, dac_reset=0 for RESET_CYCLES; unmute after SETTLE_CYCLES.
REQ-033 Glitch mcu_f for 8 cycles (< STABLE_CYCLES) -> no state change, dac_mute stays 0.
REQ-034 Change mcu_f to 11 during SETTLE -> FSM back to RESET_HOLD, dac_mute never drops, pll_s1_oe=0 after entry.
REQ-035 In RUN, mcu_mute=1 then mcu_dac_reset=0 -> dac_mute=1, dac_reset=0 within 3 cycles, busy stays 0.
REQ-036 Assert reset_mcu mid MUTE_WAIT -> outputs at REQ-028 values asynchronously, sequence restarts on release.
